// File: rtl/dmem_arbiter.sv
// dmem_arbiter: shares a single-port 256-byte data memory between port A
// (processor) and port B (decrypt/loader engine). One grant per cycle, with
// lock-based ownership, word-alignment checking, registered responses and an
// aging counter that bounds how long B can be starved while the memory is free.
module dmem_arbiter #(
  parameter int MAX_WAIT = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        a_req,
  input  logic        a_we,
  input  logic [7:0]  a_addr,
  input  logic [31:0] a_wdata,
  input  logic        a_lock,
  output logic        a_gnt,
  output logic        a_rvalid,
  output logic [31:0] a_rdata,
  output logic        a_err,
  input  logic        b_req,
  input  logic        b_we,
  input  logic [7:0]  b_addr,
  input  logic [31:0] b_wdata,
  input  logic        b_lock,
  output logic        b_gnt,
  output logic        b_rvalid,
  output logic [31:0] b_rdata,
  output logic        b_err,
  output logic        mem_we,
  output logic [7:0]  mem_addr,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata
);

  typedef enum logic [1:0] {IDLE, OWN_A, OWN_B} state_t;

  localparam logic [3:0] WAIT_LIMIT = 4'(MAX_WAIT);

  state_t      state;
  state_t      state_next;
  logic [3:0]  wait_cnt;
  logic        sel_we;
  logic [7:0]  sel_addr;
  logic [31:0] sel_wdata;
  logic        a_aligned;
  logic        b_aligned;

  assign a_aligned = (a_addr[1:0] == 2'b00);
  assign b_aligned = (b_addr[1:0] == 2'b00);

  // Pick at most one winner this cycle and work out who owns the memory next.
  always_comb begin
    a_gnt      = 1'b0;
    b_gnt      = 1'b0;
    state_next = state;
    if (!reset) begin
      case (state)
        OWN_A:   a_gnt = a_req;
        OWN_B:   b_gnt = b_req;
        default: begin
          if (b_req && (wait_cnt >= WAIT_LIMIT)) begin
            b_gnt = 1'b1;
          end else if (a_req) begin
            a_gnt = 1'b1;
          end else if (b_req) begin
            b_gnt = 1'b1;
          end
        end
      endcase
    end
    if (a_gnt) begin
      state_next = a_lock ? OWN_A : IDLE;
    end else if (b_gnt) begin
      state_next = b_lock ? OWN_B : IDLE;
    end
  end

  // Steer the granted port onto the memory bus; A's fields sit there when idle.
  always_comb begin
    sel_we    = a_we;
    sel_addr  = a_addr;
    sel_wdata = a_wdata;
    if (b_gnt) begin
      sel_we    = b_we;
      sel_addr  = b_addr;
      sel_wdata = b_wdata;
    end
    mem_we    = (a_gnt | b_gnt) & sel_we & (sel_addr[1:0] == 2'b00);
    mem_addr  = sel_addr;
    mem_wdata = sel_wdata;
    if (reset) begin
      mem_we    = 1'b0;
      mem_addr  = 8'h00;
      mem_wdata = 32'h0;
    end
  end

  // Ownership register and B's aging counter (saturates at 15).
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= IDLE;
      wait_cnt <= 4'd0;
    end else begin
      state <= state_next;
      if (!b_req || b_gnt) begin
        wait_cnt <= 4'd0;
      end else if (wait_cnt != 4'd15) begin
        wait_cnt <= wait_cnt + 4'd1;
      end
    end
  end

  // Port A response: one-cycle pulse after the grant, data/err held otherwise.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      a_rvalid <= 1'b0;
      a_rdata  <= 32'h0;
      a_err    <= 1'b0;
    end else begin
      a_rvalid <= a_gnt;
      if (a_gnt) begin
        a_err   <= !a_aligned;
        a_rdata <= (!a_we && a_aligned) ? mem_rdata : 32'h0;
      end
    end
  end

  // Port B response: same timing and hold behaviour as port A.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      b_rvalid <= 1'b0;
      b_rdata  <= 32'h0;
      b_err    <= 1'b0;
    end else begin
      b_rvalid <= b_gnt;
      if (b_gnt) begin
        b_err   <= !b_aligned;
        b_rdata <= (!b_we && b_aligned) ? mem_rdata : 32'h0;
      end
    end
  end

endmodule

// File: tb/tb_dmem_arbiter.sv
// tb_dmem_arbiter: drives dmem_arbiter with directed scenarios followed by
// random traffic and compares every output each cycle against a transaction-
// level model of who should win, what the memory bus carries and what each
// response should return.
module tb_dmem_arbiter;

  localparam int MAX_WAIT = 4;

  logic        clk;
  logic        reset;
  logic        a_req, a_we, a_lock;
  logic [7:0]  a_addr;
  logic [31:0] a_wdata;
  logic        a_gnt, a_rvalid, a_err;
  logic [31:0] a_rdata;
  logic        b_req, b_we, b_lock;
  logic [7:0]  b_addr;
  logic [31:0] b_wdata;
  logic        b_gnt, b_rvalid, b_err;
  logic [31:0] b_rdata;
  logic        mem_we;
  logic [7:0]  mem_addr;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;

  int checks = 0;
  int failures = 0;

  dmem_arbiter #(.MAX_WAIT(MAX_WAIT)) dut (
    .clk(clk), .reset(reset),
    .a_req(a_req), .a_we(a_we), .a_addr(a_addr), .a_wdata(a_wdata), .a_lock(a_lock),
    .a_gnt(a_gnt), .a_rvalid(a_rvalid), .a_rdata(a_rdata), .a_err(a_err),
    .b_req(b_req), .b_we(b_we), .b_addr(b_addr), .b_wdata(b_wdata), .b_lock(b_lock),
    .b_gnt(b_gnt), .b_rvalid(b_rvalid), .b_rdata(b_rdata), .b_err(b_err),
    .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
  );

  // Free-running 10 ns clock.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic logic [7:0] initByte(input int i);
    return 8'(i * 37 + 11);
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s actual=0x%08h expected=0x%08h at %0t", name, actual, expected, $time);
    end
  endtask

  task automatic applyStimulus(input logic ar, input logic aw, input logic [7:0] aa,
                               input logic [31:0] ad, input logic al,
                               input logic br, input logic bw, input logic [7:0] ba,
                               input logic [31:0] bd, input logic bl);
    a_req = ar; a_we = aw; a_addr = aa; a_wdata = ad; a_lock = al;
    b_req = br; b_we = bw; b_addr = ba; b_wdata = bd; b_lock = bl;
  endtask

  // Byte-wide single-port memory behind the arbiter, big-endian words.
  logic [7:0] env_mem [256];
  bit         env_ready = 1'b0;

  always @(posedge clk) begin
    if (!env_ready) begin
      for (int i = 0; i < 256; i++) env_mem[i] <= initByte(i);
      env_ready <= 1'b1;
    end else if (mem_we) begin
      env_mem[mem_addr]        <= mem_wdata[31:24];
      env_mem[mem_addr + 8'd1] <= mem_wdata[23:16];
      env_mem[mem_addr + 8'd2] <= mem_wdata[15:8];
      env_mem[mem_addr + 8'd3] <= mem_wdata[7:0];
    end
  end

  assign mem_rdata = mem_we ? 32'h0 :
                     {env_mem[mem_addr], env_mem[mem_addr + 8'd1],
                      env_mem[mem_addr + 8'd2], env_mem[mem_addr + 8'd3]};

  // Reference model state: owner 0=none, 1=A, 2=B; age counts refused B cycles.
  logic [7:0]  model_mem [256];
  bit          model_ready = 1'b0;
  int          owner = 0;
  int          age = 0;
  logic        exp_a_rvalid = 1'b0, exp_a_err = 1'b0;
  logic        exp_b_rvalid = 1'b0, exp_b_err = 1'b0;
  logic [31:0] exp_a_rdata = 32'h0, exp_b_rdata = 32'h0;
  logic        m_ga = 1'b0, m_gb = 1'b0;

  function automatic logic [31:0] modelWord(input logic [7:0] ad);
    return {model_mem[ad], model_mem[ad + 8'd1], model_mem[ad + 8'd2], model_mem[ad + 8'd3]};
  endfunction

  // Compare process: checks every output each cycle, then advances the model.
  always @(negedge clk or posedge reset) begin
    logic        ga, gb, we;
    logic [7:0]  ad;
    logic [31:0] wd;
    if (!model_ready) begin
      for (int i = 0; i < 256; i++) model_mem[i] = initByte(i);
      model_ready = 1'b1;
    end
    if (reset) begin
      owner = 0; age = 0; m_ga = 1'b0; m_gb = 1'b0;
      exp_a_rvalid = 1'b0; exp_a_err = 1'b0; exp_a_rdata = 32'h0;
      exp_b_rvalid = 1'b0; exp_b_err = 1'b0; exp_b_rdata = 32'h0;
      #1;
      if (reset) begin
        checkOutput("rst_a_gnt", 32'(a_gnt), 32'h0);
        checkOutput("rst_b_gnt", 32'(b_gnt), 32'h0);
        checkOutput("rst_mem_we", 32'(mem_we), 32'h0);
        checkOutput("rst_mem_addr", 32'(mem_addr), 32'h0);
        checkOutput("rst_mem_wdata", mem_wdata, 32'h0);
        checkOutput("rst_a_rvalid", 32'(a_rvalid), 32'h0);
        checkOutput("rst_b_rvalid", 32'(b_rvalid), 32'h0);
        checkOutput("rst_a_rdata", a_rdata, 32'h0);
        checkOutput("rst_b_rdata", b_rdata, 32'h0);
      end
    end else begin
      checkOutput("a_rvalid", 32'(a_rvalid), 32'(exp_a_rvalid));
      checkOutput("a_rdata", a_rdata, exp_a_rdata);
      checkOutput("a_err", 32'(a_err), 32'(exp_a_err));
      checkOutput("b_rvalid", 32'(b_rvalid), 32'(exp_b_rvalid));
      checkOutput("b_rdata", b_rdata, exp_b_rdata);
      checkOutput("b_err", 32'(b_err), 32'(exp_b_err));

      ga = 1'b0; gb = 1'b0;
      if (owner == 1) ga = a_req;
      else if (owner == 2) gb = b_req;
      else if (b_req && age >= MAX_WAIT) gb = 1'b1;
      else if (a_req) ga = 1'b1;
      else if (b_req) gb = 1'b1;
      checkOutput("a_gnt", 32'(a_gnt), 32'(ga));
      checkOutput("b_gnt", 32'(b_gnt), 32'(gb));

      if (gb) begin we = b_we; ad = b_addr; wd = b_wdata; end
      else    begin we = a_we; ad = a_addr; wd = a_wdata; end
      checkOutput("mem_we", 32'(mem_we), 32'((ga || gb) && we && ad[1:0] == 2'b00));
      checkOutput("mem_addr", 32'(mem_addr), 32'(ad));
      checkOutput("mem_wdata", mem_wdata, wd);

      if (ga) begin
        exp_a_err   = (a_addr[1:0] != 2'b00);
        exp_a_rdata = (!a_we && !exp_a_err) ? modelWord(a_addr) : 32'h0;
        owner       = a_lock ? 1 : 0;
      end
      if (gb) begin
        exp_b_err   = (b_addr[1:0] != 2'b00);
        exp_b_rdata = (!b_we && !exp_b_err) ? modelWord(b_addr) : 32'h0;
        owner       = b_lock ? 2 : 0;
      end
      exp_a_rvalid = ga;
      exp_b_rvalid = gb;
      if ((ga || gb) && we && ad[1:0] == 2'b00) begin
        model_mem[ad]        = wd[31:24];
        model_mem[ad + 8'd1] = wd[23:16];
        model_mem[ad + 8'd2] = wd[15:8];
        model_mem[ad + 8'd3] = wd[7:0];
      end
      age  = (!b_req || gb) ? 0 : ((age < 15) ? age + 1 : 15);
      m_ga = ga;
      m_gb = gb;
    end
  end

  // Directed scenarios with literal expectations, then random traffic.
  initial begin
    logic [31:0] r;
    logic        nar, naw, nal, nbr, nbw, nbl;
    logic [7:0]  naa, nba;
    logic [31:0] nad, nbd;

    reset = 1'b1;
    applyStimulus(1'b1, 1'b0, 8'h55, 32'hDEADBEEF, 1'b0, 1'b1, 1'b1, 8'h66, 32'h12345678, 1'b0);
    repeat (3) @(negedge clk);
    #2;
    checkOutput("lit_reset_a_gnt", 32'(a_gnt), 32'h0);
    checkOutput("lit_reset_mem_addr", 32'(mem_addr), 32'h0);
    checkOutput("lit_reset_mem_wdata", mem_wdata, 32'h0);

    @(posedge clk); #1;
    reset = 1'b0;
    applyStimulus(1'b1, 1'b1, 8'h10, 32'h11223344, 1'b0, 1'b0, 1'b0, 8'h00, 32'h0, 1'b0);
    @(negedge clk);
    checkOutput("lit_wr_a_gnt", 32'(a_gnt), 32'h1);
    checkOutput("lit_wr_mem_we", 32'(mem_we), 32'h1);
    checkOutput("lit_wr_mem_addr", 32'(mem_addr), 32'h10);
    checkOutput("lit_wr_mem_wdata", mem_wdata, 32'h11223344);
    @(posedge clk); #1;
    applyStimulus(1'b1, 1'b0, 8'h10, 32'h0, 1'b0, 1'b0, 1'b0, 8'h00, 32'h0, 1'b0);
    @(negedge clk);
    checkOutput("lit_wr_resp_rvalid", 32'(a_rvalid), 32'h1);
    checkOutput("lit_wr_resp_rdata", a_rdata, 32'h0);
    @(posedge clk); #1;
    applyStimulus(1'b0, 1'b0, 8'h00, 32'h0, 1'b0, 1'b0, 1'b0, 8'h00, 32'h0, 1'b0);
    @(negedge clk);
    checkOutput("lit_rd_resp_rvalid", 32'(a_rvalid), 32'h1);
    checkOutput("lit_rd_resp_rdata", a_rdata, 32'h11223344);
    checkOutput("lit_rd_resp_err", 32'(a_err), 32'h0);

    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      applyStimulus(1'b1, 1'b0, 8'h30, 32'h0, 1'b0, 1'b1, 1'b0, 8'h34, 32'h0, 1'b0);
      @(negedge clk);
      checkOutput("lit_aging_b_gnt", 32'(b_gnt), 32'((i % 5) == 4));
      checkOutput("lit_aging_a_gnt", 32'(a_gnt), 32'((i % 5) != 4));
    end

    @(posedge clk); #1;
    applyStimulus(1'b0, 1'b0, 8'h00, 32'h0, 1'b0, 1'b1, 1'b0, 8'h13, 32'h0, 1'b0);
    @(negedge clk);
    checkOutput("lit_mis_b_gnt", 32'(b_gnt), 32'h1);
    checkOutput("lit_mis_mem_we", 32'(mem_we), 32'h0);
    @(posedge clk); #1;
    applyStimulus(1'b0, 1'b0, 8'h00, 32'h0, 1'b0, 1'b0, 1'b0, 8'h00, 32'h0, 1'b0);
    @(negedge clk);
    checkOutput("lit_mis_b_rvalid", 32'(b_rvalid), 32'h1);
    checkOutput("lit_mis_b_err", 32'(b_err), 32'h1);
    checkOutput("lit_mis_b_rdata", b_rdata, 32'h0);

    @(posedge clk); #1;
    applyStimulus(1'b1, 1'b0, 8'h20, 32'h0, 1'b1, 1'b1, 1'b0, 8'h44, 32'h0, 1'b0);
    @(negedge clk);
    checkOutput("lit_lock_a_gnt", 32'(a_gnt), 32'h1);
    for (int i = 0; i < 20; i++) begin
      @(posedge clk); #1;
      applyStimulus(1'b0, 1'b0, 8'h00, 32'h0, 1'b0, 1'b1, 1'b0, 8'h44, 32'h0, 1'b0);
      @(negedge clk);
      checkOutput("lit_lock_b_refused", 32'(b_gnt), 32'h0);
    end
    @(posedge clk); #1;
    applyStimulus(1'b1, 1'b1, 8'h20, 32'hCAFEF00D, 1'b0, 1'b1, 1'b0, 8'h44, 32'h0, 1'b0);
    @(negedge clk);
    checkOutput("lit_unlock_a_gnt", 32'(a_gnt), 32'h1);
    checkOutput("lit_unlock_b_gnt", 32'(b_gnt), 32'h0);
    @(posedge clk); #1;
    applyStimulus(1'b0, 1'b0, 8'h00, 32'h0, 1'b0, 1'b1, 1'b0, 8'h44, 32'h0, 1'b0);
    @(negedge clk);
    checkOutput("lit_after_unlock_b_gnt", 32'(b_gnt), 32'h1);

    @(posedge clk); #1;
    applyStimulus(1'b0, 1'b0, 8'h00, 32'h0, 1'b0, 1'b1, 1'b0, 8'h40, 32'h0, 1'b0);
    @(negedge clk);
    checkOutput("lit_midrst_b_gnt", 32'(b_gnt), 32'h1);
    #1;
    reset = 1'b1;
    applyStimulus(1'b0, 1'b0, 8'h00, 32'h0, 1'b0, 1'b0, 1'b0, 8'h00, 32'h0, 1'b0);
    #2;
    reset = 1'b0;
    @(posedge clk); #1;
    @(negedge clk);
    checkOutput("lit_midrst_b_rvalid", 32'(b_rvalid), 32'h0);

    for (int i = 0; i < 3000; i++) begin
      @(posedge clk); #1;
      nar = a_req; naw = a_we; naa = a_addr; nad = a_wdata; nal = a_lock;
      nbr = b_req; nbw = b_we; nba = b_addr; nbd = b_wdata; nbl = b_lock;
      if (!(a_req && !m_ga)) begin
        r   = $urandom;
        nar = (r[1:0] != 2'b00);
        naw = r[2];
        nal = (r[4:3] == 2'b00);
        naa = (r[7:5] == 3'b000) ? r[15:8] : {2'b00, r[11:8], 2'b00};
        nad = $urandom;
      end
      if (!(b_req && !m_gb)) begin
        r   = $urandom;
        nbr = r[0];
        nbw = r[2];
        nbl = (r[4:3] == 2'b00);
        nba = (r[7:5] == 3'b000) ? r[15:8] : {2'b00, r[11:8], 2'b00};
        nbd = $urandom;
      end
      applyStimulus(nar, naw, naa, nad, nal, nbr, nbw, nba, nbd, nbl);
    end

    @(posedge clk); #1;
    applyStimulus(1'b0, 1'b0, 8'h00, 32'h0, 1'b0, 1'b0, 1'b0, 8'h00, 32'h0, 1'b0);
    repeat (3) @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
